// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin arbiter granting a 4-digit display to two requesters with a minimum dwell
module seg_display_arbiter #(
  parameter int DWELL = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack1,
  output logic [3:0]  in0,
  output logic [3:0]  in1,
  output logic [3:0]  in2,
  output logic [3:0]  in3,
  output logic        owner,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW0 = 2'd1;
  localparam logic [1:0] SHOW1 = 2'd2;

  // Terminal count of a dwell; the counter clears here, so it never wraps.
  localparam logic [26:0] LAST_COUNT = 27'(DWELL - 1);

  logic [1:0]  state;
  logic [26:0] count;
  logic        last_grant;
  logic [15:0] disp;

  logic        arb_window;
  logic        gnt_valid;
  logic        gnt_idx;

  // Arbitration is open in IDLE or on the last cycle of a dwell; ties go to the requester not served last.
  always_comb begin
    arb_window = (state == IDLE) || (count == LAST_COUNT);
    gnt_valid  = arb_window && (req0 || req1);
    gnt_idx    = (req0 && req1) ? ~last_grant : req1;
  end

  // State, dwell counter, latched display value and one-cycle acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      busy       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      disp       <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (gnt_valid) begin
        state      <= gnt_idx ? SHOW1 : SHOW0;
        ack0       <= ~gnt_idx;
        ack1       <= gnt_idx;
        disp       <= gnt_idx ? data1 : data0;
        owner      <= gnt_idx;
        last_grant <= gnt_idx;
        count      <= '0;
        busy       <= 1'b1;
      end else if (state != IDLE) begin
        if (count == LAST_COUNT) begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end else begin
          count <= count + 27'd1;
        end
      end
    end
  end

  assign in3 = disp[15:12];
  assign in2 = disp[11:8];
  assign in1 = disp[7:4];
  assign in0 = disp[3:0];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed self-checking bench for seg_display_arbiter
module tb_seg_display_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // DWELL = 4 instance
  logic        a_reset, a_req0, a_req1, a_ack0, a_ack1, a_owner, a_busy;
  logic [15:0] a_data0, a_data1;
  logic [3:0]  a_in0, a_in1, a_in2, a_in3;
  // DWELL = 8 instance
  logic        b_reset, b_req0, b_req1, b_ack0, b_ack1, b_owner, b_busy;
  logic [15:0] b_data0, b_data1;
  logic [3:0]  b_in0, b_in1, b_in2, b_in3;
  // DWELL = 1 instance
  logic        c_reset, c_req0, c_req1, c_ack0, c_ack1, c_owner, c_busy;
  logic [15:0] c_data0, c_data1;
  logic [3:0]  c_in0, c_in1, c_in2, c_in3;

  seg_display_arbiter #(.DWELL(4)) u_a (
    .clk(clk), .reset(a_reset), .req0(a_req0), .data0(a_data0), .ack0(a_ack0),
    .req1(a_req1), .data1(a_data1), .ack1(a_ack1),
    .in0(a_in0), .in1(a_in1), .in2(a_in2), .in3(a_in3), .owner(a_owner), .busy(a_busy)
  );

  seg_display_arbiter #(.DWELL(8)) u_b (
    .clk(clk), .reset(b_reset), .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
    .req1(b_req1), .data1(b_data1), .ack1(b_ack1),
    .in0(b_in0), .in1(b_in1), .in2(b_in2), .in3(b_in3), .owner(b_owner), .busy(b_busy)
  );

  seg_display_arbiter #(.DWELL(1)) u_c (
    .clk(clk), .reset(c_reset), .req0(c_req0), .data0(c_data0), .ack0(c_ack0),
    .req1(c_req1), .data1(c_data1), .ack1(c_ack1),
    .in0(c_in0), .in1(c_in1), .in2(c_in2), .in3(c_in3), .owner(c_owner), .busy(c_busy)
  );

  wire [15:0] a_disp = {a_in3, a_in2, a_in1, a_in0};
  wire [15:0] b_disp = {b_in3, b_in2, b_in1, b_in0};
  wire [15:0] c_disp = {c_in3, c_in2, c_in1, c_in0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks acks/owner/busy/display of instance A in one call.
  task automatic chk_a(input string tag, input logic e_ack0, input logic e_ack1,
                       input logic e_owner, input logic e_busy, input logic [15:0] e_disp);
    chk({tag, ".ack0"}, {31'd0, a_ack0}, {31'd0, e_ack0});
    chk({tag, ".ack1"}, {31'd0, a_ack1}, {31'd0, e_ack1});
    chk({tag, ".owner"}, {31'd0, a_owner}, {31'd0, e_owner});
    chk({tag, ".busy"}, {31'd0, a_busy}, {31'd0, e_busy});
    chk({tag, ".disp"}, {16'd0, a_disp}, {16'd0, e_disp});
  endtask

  initial begin
    a_reset = 1'b1; a_req0 = 1'b0; a_req1 = 1'b0; a_data0 = 16'hDEAD; a_data1 = 16'hBEEF;
    b_reset = 1'b1; b_req0 = 1'b0; b_req1 = 1'b0; b_data0 = 16'h0000; b_data1 = 16'h0000;
    c_reset = 1'b1; c_req0 = 1'b0; c_req1 = 1'b0; c_data0 = 16'h0000; c_data1 = 16'h0000;

    // Reset state
    tick();
    chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Single req0, DWELL=4: ack next cycle, busy for 4 cycles, then IDLE holding display
    a_reset = 1'b0; a_req0 = 1'b1; a_data0 = 16'h1234;
    tick();
    chk_a("single.grant", 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    a_req0 = 1'b0; a_data0 = 16'h9999;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_a($sformatf("single.dwell%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    end
    tick();
    chk_a("single.idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
    tick();
    chk_a("single.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);

    // Tie from reset: req0 wins, then req1 gets the display at the end of the dwell
    a_reset = 1'b1;
    tick();
    chk_a("tie.reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    a_reset = 1'b0; a_req0 = 1'b1; a_req1 = 1'b1; a_data0 = 16'h1234; a_data1 = 16'hABCD;
    tick();
    chk_a("tie.ack0", 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    a_req0 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_a($sformatf("tie.dwell%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    end
    tick();
    chk_a("tie.ack1", 1'b0, 1'b1, 1'b1, 1'b1, 16'hABCD);

    // req1 held continuously: re-granted every 4 cycles, ack0 never
    for (int p = 0; p < 3; p++) begin
      for (int i = 1; i <= 3; i++) begin
        tick();
        chk_a($sformatf("hold.p%0d.c%0d", p, i), 1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD);
      end
      tick();
      chk_a($sformatf("hold.p%0d.regrant", p), 1'b0, 1'b1, 1'b1, 1'b1, 16'hABCD);
    end
    a_req1 = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    tick();
    chk_a("hold.idle", 1'b0, 1'b0, 1'b1, 1'b0, 16'hABCD);

    // req1 pulsed during SHOW0 and dropped before the end of dwell: forgotten
    a_req0 = 1'b1; a_data0 = 16'h5A5A; a_data1 = 16'hFFFF;
    tick();
    chk_a("drop.ack0", 1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A);
    a_req0 = 1'b0; a_req1 = 1'b1;
    tick();
    chk_a("drop.c1", 1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A);
    tick();
    chk_a("drop.c2", 1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A);
    a_req1 = 1'b0;
    tick();
    chk_a("drop.c3", 1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A);
    tick();
    chk_a("drop.idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A);
    tick();
    chk_a("drop.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A);

    // DWELL=8: reset at count=5 in SHOW1 aborts; req0 re-arbitrated right after release
    b_reset = 1'b0; b_req1 = 1'b1; b_data1 = 16'h0F0F;
    tick();
    chk("abort.ack1", {31'd0, b_ack1}, 32'd1);
    chk("abort.owner1", {31'd0, b_owner}, 32'd1);
    b_req1 = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk("abort.busy_mid", {31'd0, b_busy}, 32'd1);
    b_reset = 1'b1; b_req0 = 1'b1; b_data0 = 16'h1357;
    tick();
    chk("abort.rst.ack0", {31'd0, b_ack0}, 32'd0);
    chk("abort.rst.ack1", {31'd0, b_ack1}, 32'd0);
    chk("abort.rst.owner", {31'd0, b_owner}, 32'd0);
    chk("abort.rst.busy", {31'd0, b_busy}, 32'd0);
    chk("abort.rst.disp", {16'd0, b_disp}, 32'd0);
    b_reset = 1'b0;
    tick();
    chk("abort.rel.ack0", {31'd0, b_ack0}, 32'd1);
    chk("abort.rel.ack1", {31'd0, b_ack1}, 32'd0);
    chk("abort.rel.disp", {16'd0, b_disp}, 32'h1357);
    chk("abort.rel.busy", {31'd0, b_busy}, 32'd1);
    b_req0 = 1'b0;

    // DWELL=1 with both reqs held: grants alternate every cycle, starting with req0
    c_reset = 1'b0; c_req0 = 1'b1; c_req1 = 1'b1; c_data0 = 16'h1111; c_data1 = 16'h2222;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("alt%0d.ack0", i), {31'd0, c_ack0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d.ack1", i), {31'd0, c_ack1}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("alt%0d.disp", i), {16'd0, c_disp}, (i % 2 == 0) ? 32'h1111 : 32'h2222);
      chk($sformatf("alt%0d.owner", i), {31'd0, c_owner}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("alt%0d.busy", i), {31'd0, c_busy}, 32'd1);
    end
    c_req0 = 1'b0; c_req1 = 1'b0;
    tick();
    tick();
    chk("alt.idle.busy", {31'd0, c_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter DWELL, default 50_000_000, minimum display time in clk cycles per grant; legal range 1 to 2^27-1.
REQ-002 clk  input  1  system clock (100 MHz); all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 asks for the display; level, held until ack0.
REQ-005 data0  input  16  requester 0 value, 4 hex nibbles; [15:12] = leftmost digit.
REQ-006 ack0  output  1  one-cycle pulse; data0 captured this cycle.
REQ-007 req1  input  1  requester 1 asks for the display; level, held until ack1.
REQ-008 data1  input  16  requester 1 value, same nibble order as data0.
REQ-009 ack1  output  1  one-cycle pulse; data1 captured this cycle.
REQ-010 in0, in1, in2, in3  output  4 each  digit values for the 4-digit seven-segment driver; in3 = leftmost, in0 = rightmost.
REQ-011 owner  output  1  index of the requester whose value is currently displayed.
REQ-012 busy  output  1  high while a dwell period is running.

Function
REQ-013 FSM states: IDLE, SHOW0, SHOW1; state, registers and outputs are all registered.
REQ-014 IDLE, only req0 high -> next cycle SHOW0, ack0=1, data0 latched, owner=0, dwell counter cleared.
REQ-015 IDLE, only req1 high -> next cycle SHOW1, ack1=1, data1 latched, owner=1, dwell counter cleared.
REQ-016 IDLE, req0 and req1 both high -> grant the requester not equal to last_grant (round-robin); last_grant = 1 after reset, so req0 wins the first tie.
REQ-017 Grant cycle updates last_grant to the granted index; exactly one ack pulses, for exactly one cycle.
REQ-018 in3..in0 = latched data[15:12], [11:8], [7:4], [3:0]; they change only on the cycle after a grant and hold between grants, including in IDLE.
REQ-019 SHOWx: counter increments every cycle; busy=1; requests are ignored and no ack is issued until count = DWELL-1.
REQ-020 At count = DWELL-1 with the other requester's req high -> switch directly to the other SHOW state: ack it, latch its data, clear the counter; no IDLE cycle in between.
REQ-021 At count = DWELL-1 with only the current owner's req high -> re-grant the same owner: ack, relatch, clear the counter.
REQ-022 At count = DWELL-1 with no req high -> IDLE; busy=0; display and owner hold.
REQ-023 Counter is 27 bits, never wraps, and clears on every grant.
REQ-024 DWELL=1 -> each grant lasts exactly one cycle; with both reqs held, grants alternate every cycle.
REQ-025 A req dropped before its ack is not remembered and produces no later ack.
REQ-026 ack0 and ack1 are never high in the same cycle.

Reset
REQ-027 When reset is high at a clk edge -> state IDLE, counter 0, last_grant 1, owner 0, busy 0, ack0 = ack1 = 0, in0..in3 = 0.
REQ-028 Reset mid-dwell aborts the grant; pending reqs are re-arbitrated per REQ-014..016 starting on the first cycle after reset deasserts.
REQ-029 Reset has priority over every other event in the same cycle.

Verification
REQ-030 DWELL=4; reset; req0=1, data0=16'h1234 for 1 cycle -> ack0 next cycle; in3..in0 = 1,2,3,4; owner=0; busy=1 for 4 cycles, then IDLE with the display held.
REQ-031 DWELL=4; req0 and req1 both high from IDLE, data1=16'hABCD -> ack0 first; ack1 at the cycle count=3 ends the first dwell; display becomes A,B,C,D; owner=1.
REQ-032 DWELL=4; req1 held high continuously -> ack1 every 4 cycles, ack0 never.
REQ-033 DWELL=4; during SHOW0, req1 pulsed for 2 cycles and dropped before count=3 -> no ack1; return to IDLE; display keeps data0.
REQ-034 DWELL=8; reset asserted at count=5 in SHOW1 -> next cycle all outputs take REQ-027 values; with req0 high after release -> ack0 one cycle later.
REQ-035 DWELL=1; both reqs held -> ack0, ack1 alternate every cycle, never simultaneous; in3..in0 alternate between data0 and data1.
